// File: rtl/hdpldadapt_sr_tx_seq_if.sv
// hdpldadapt_sr_tx_seq_if: config, parallel data and serial outputs of the SR transmit sequencer
interface hdpldadapt_sr_tx_seq_if #(
    parameter logic [6:0] NUM_OF_PCS_CHAIN            = 7'd16,
    parameter logic [6:0] NUM_OF_HIP_CHAIN            = 7'd16,
    parameter logic [6:0] NUM_OF_RESERVED_CHAIN_SSRIN = 7'd5
);
    logic                                   transfer_en;
    logic                                   r_sr_hip_en;
    logic                                   r_sr_parity_en;
    logic                                   r_sr_reserbits_in_en;
    logic [NUM_OF_PCS_CHAIN-1:0]            pcs_data;
    logic [NUM_OF_HIP_CHAIN-1:0]            hip_data;
    logic [NUM_OF_RESERVED_CHAIN_SSRIN-1:0] rsv_data;
    logic                                   sr_loadout;
    logic                                   sr_dataout;
    logic                                   frame_done;
    logic [11:0]                            sr_seq_testbus;

    modport master (
        output transfer_en, r_sr_hip_en, r_sr_parity_en, r_sr_reserbits_in_en,
        output pcs_data, hip_data, rsv_data,
        input  sr_loadout, sr_dataout, frame_done, sr_seq_testbus
    );

    modport slave (
        input  transfer_en, r_sr_hip_en, r_sr_parity_en, r_sr_reserbits_in_en,
        input  pcs_data, hip_data, rsv_data,
        output sr_loadout, sr_dataout, frame_done, sr_seq_testbus
    );
endinterface

// File: rtl/hdpldadapt_sr_tx_seq.sv
// hdpldadapt_sr_tx_seq: serialises PCS/HIP/reserved words (plus optional parity) into LOAD/SHIFT frames
module hdpldadapt_sr_tx_seq #(
    parameter logic [6:0] NUM_OF_PCS_CHAIN            = 7'd16,
    parameter logic [6:0] NUM_OF_HIP_CHAIN            = 7'd16,
    parameter logic [6:0] NUM_OF_RESERVED_CHAIN_SSRIN = 7'd5
) (
    input logic                     clk,
    input logic                     rst,
    hdpldadapt_sr_tx_seq_if.slave   bus
);
    localparam int W = int'(NUM_OF_PCS_CHAIN) + int'(NUM_OF_HIP_CHAIN) + int'(NUM_OF_RESERVED_CHAIN_SSRIN) + 1;

    typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, SHIFT = 2'b10} state_t;

    state_t         state, nxt;
    logic [6:0]     bit_cnt, cnt_n, len, len_n;
    logic [W-1:0]   sreg, fv;
    logic           par_q, par_n, last;

    // Frame vector is packed LSB-first so the shift register simply drains bit 0 each SHIFT cycle
    always_comb begin
        par_n = ^bus.pcs_data ^ (bus.r_sr_hip_en & ^bus.hip_data) ^ (bus.r_sr_reserbits_in_en & ^bus.rsv_data);
        len_n = NUM_OF_PCS_CHAIN + (bus.r_sr_hip_en ? NUM_OF_HIP_CHAIN : 7'd0)
              + (bus.r_sr_reserbits_in_en ? NUM_OF_RESERVED_CHAIN_SSRIN : 7'd0)
              + (bus.r_sr_parity_en ? 7'd1 : 7'd0);
        fv = W'(bus.pcs_data);
        if (bus.r_sr_hip_en)
            fv = fv | (W'(bus.hip_data) << NUM_OF_PCS_CHAIN);
        if (bus.r_sr_reserbits_in_en)
            fv = fv | (W'(bus.rsv_data) << (bus.r_sr_hip_en ? NUM_OF_PCS_CHAIN + NUM_OF_HIP_CHAIN : NUM_OF_PCS_CHAIN));
        if (bus.r_sr_parity_en)
            fv = fv | (W'(par_n) << (len_n - 7'd1));
        last  = bit_cnt == len - 7'd1;
        nxt   = !bus.transfer_en ? IDLE :
                state == IDLE    ? LOAD :
                state == LOAD    ? SHIFT :
                state == SHIFT   ? (last ? LOAD : SHIFT) : IDLE;
        cnt_n = (state == SHIFT && nxt == SHIFT) ? bit_cnt + 7'd1 : 7'd0;
    end

    // Outputs are computed from the next state so they line up with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            sreg           <= '0;
            len            <= '0;
            par_q          <= 1'b0;
            bus.sr_loadout <= 1'b1;
            bus.sr_dataout <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= nxt;
            bit_cnt        <= cnt_n;
            bus.sr_loadout <= nxt != SHIFT;
            bus.sr_dataout <= nxt == SHIFT && sreg[0];
            bus.frame_done <= nxt == SHIFT && cnt_n == len - 7'd1;
            if (nxt == LOAD) begin
                sreg  <= fv;
                len   <= len_n;
                par_q <= par_n;
            end else if (nxt == SHIFT) begin
                sreg  <= sreg >> 1;
            end
        end
    end

    assign bus.sr_seq_testbus = {bus.transfer_en, state, bus.frame_done, bit_cnt, par_q};
endmodule
